// File: rtl/cordic_arb.sv
// Round-robin arbiter sharing one combinational cosine CORDIC among NREQ requesters (stats: CORDIC_ARB_STATS_EN).
// Latency: accept at T, rsp_valid at T+1+LATENCY; one op per LATENCY+2 cycles back-to-back.
// Backpressure: req_ready only in IDLE; the response is held until the granted requester's rsp_ready.
module cordic_arb #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 2,
  parameter int ANGLE_W = 32,
  parameter int RES_W   = 16
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*ANGLE_W-1:0] req_angle,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [RES_W-1:0]        rsp_cosine,
  output logic [ANGLE_W-1:0]      cordic_angle,
  input  logic [RES_W-1:0]        cordic_cosine,
`ifdef CORDIC_ARB_STATS_EN
  output logic [15:0]             stat_done,
`endif
  output logic                    busy
);

  localparam int GW = $clog2(NREQ);
  localparam int SW = GW + 1;

  if (NREQ < 2 || NREQ > 8 || LATENCY < 1 || LATENCY > 15) begin : g_param_check
    $error("cordic_arb: NREQ must be 2..8 and LATENCY 1..15");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] grant;
  logic [3:0]    cnt;

  logic          any_req;
  logic [SW-1:0] cand_sum;
  logic [GW-1:0] cand;
  logic [GW-1:0] pick;
  logic [GW-1:0] next_ptr;

  assign any_req = |req_valid;

  // Walk from the farthest candidate back to rr_ptr so the closest valid one wins.
  always_comb begin
    pick     = rr_ptr;
    cand_sum = '0;
    cand     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand_sum = {1'b0, rr_ptr} + SW'(i);
      if (cand_sum >= SW'(NREQ)) cand_sum = cand_sum - SW'(NREQ);
      cand = cand_sum[GW-1:0];
      if (req_valid[cand]) pick = cand;
    end
  end

  assign next_ptr  = (pick == GW'(NREQ - 1)) ? '0 : pick + GW'(1);
  assign req_ready = (state == IDLE && !rst && any_req) ? (NREQ'(1) << pick) : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant        <= '0;
      cnt          <= '0;
      cordic_angle <= '0;
      rsp_cosine   <= '0;
      rsp_valid    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            cordic_angle <= req_angle[pick*ANGLE_W +: ANGLE_W];
            grant        <= pick;
            cnt          <= 4'(LATENCY);
            rr_ptr       <= next_ptr;
            state        <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          // Last settle cycle: the CORDIC output has been stable for LATENCY cycles.
          if (cnt == 4'd1) begin
            rsp_cosine <= cordic_cosine;
            rsp_valid  <= NREQ'(1) << grant;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[grant]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CORDIC_ARB_STATS_EN
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      stat_done <= '0;
    end else if (state == RESP && rsp_ready[grant] && stat_done != 16'hFFFF) begin
      stat_done <= stat_done + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cordic_arb.sv
// Directed bench for cordic_arb with a CORDIC stub returning cordic_angle[31:16].
module tb_cordic_arb;

  logic         clock;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_angle;
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic [15:0]  rsp_cosine;
  logic [31:0]  cordic_angle;
  logic [15:0]  cordic_cosine;
  logic         busy;
`ifdef CORDIC_ARB_STATS_EN
  logic [15:0]  stat_done;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  cordic_arb #(.NREQ(4), .LATENCY(2), .ANGLE_W(32), .RES_W(16)) dut (
    .clock         (clock),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_angle     (req_angle),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_cosine    (rsp_cosine),
    .cordic_angle  (cordic_angle),
    .cordic_cosine (cordic_cosine),
`ifdef CORDIC_ARB_STATS_EN
    .stat_done     (stat_done),
`endif
    .busy          (busy)
  );

  assign cordic_cosine = cordic_angle[31:16];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_angle = '0;
    rsp_ready = 4'b0000;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cordic_angle", cordic_angle, 32'h0);
    chk("rst_rsp_cosine", 32'(rsp_cosine), 32'h0);
    tick();
    tick();
    rst       = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("idle_busy", 32'(busy), 32'h0);

    // Single request from requester 1, cycle T
    req_valid = 4'b0010;
    req_angle[32 +: 32] = 32'h4000_0000;
    #1;
    chk("single_req_ready_T", 32'(req_ready), 32'h2);
    chk("single_busy_T", 32'(busy), 32'h0);
    tick();  // T+1
    req_valid = 4'b0000;
    #1;
    chk("single_busy_T1", 32'(busy), 32'h1);
    chk("single_cordic_angle", cordic_angle, 32'h4000_0000);
    chk("single_rsp_valid_T1", 32'(rsp_valid), 32'h0);
    tick();  // T+2
    chk("single_rsp_valid_T2", 32'(rsp_valid), 32'h0);
    chk("single_busy_T2", 32'(busy), 32'h1);
    tick();  // T+3
    chk("single_rsp_valid_T3", 32'(rsp_valid), 32'h2);
    chk("single_rsp_cosine_T3", 32'(rsp_cosine), 32'h4000);

    // Backpressure; non-granted rsp_ready bits must be ignored
    req_valid = 4'b1111;
    rsp_ready = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("bp_rsp_cosine", 32'(rsp_cosine), 32'h4000);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      chk("bp_busy", 32'(busy), 32'h1);
    end
    req_valid = 4'b0000;
    rsp_ready = 4'b0010;
    tick();
    chk("release_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("release_busy", 32'(busy), 32'h0);
    rsp_ready = 4'b0000;

    // Reset in the middle of BUSY
    req_valid = 4'b0001;
    req_angle[0 +: 32] = 32'h1234_5678;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("midrst_cordic_angle_busy", cordic_angle, 32'h1234_5678);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_cordic_angle", cordic_angle, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("postrst_rsp_valid", 32'(rsp_valid), 32'h0);

    // Only requester 3 valid after reset
    req_valid = 4'b1000;
    req_angle[96 +: 32] = 32'h7000_0000;
    #1;
    chk("r3_req_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0000;
    rsp_ready = 4'b1111;
    tick();
    tick();
    chk("r3_rsp_valid", 32'(rsp_valid), 32'h8);
    chk("r3_rsp_cosine", 32'(rsp_cosine), 32'h7000);
    tick();
    chk("r3_done_busy", 32'(busy), 32'h0);

    // Wrap: after grant to 3, requesters 0 and 3 compete
    req_angle = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    req_valid = 4'b1001;
    #1;
    chk("wrap_req_ready", 32'(req_ready), 32'h1);

    // All four continuously: grants 0,1,2,3,0 spaced 4 cycles
    req_valid = 4'b1111;
    #1;
    for (int j = 0; j < 5; j++) begin
      chk("rr_req_ready", 32'(req_ready), 32'(1 << (j % 4)));
      tick();
      chk("rr_req_ready_busy", 32'(req_ready), 32'h0);
      chk("rr_cordic_angle", cordic_angle, 32'((j % 4) << 28));
      tick();
      chk("rr_rsp_valid_early", 32'(rsp_valid), 32'h0);
      tick();
      chk("rr_rsp_valid", 32'(rsp_valid), 32'(1 << (j % 4)));
      chk("rr_rsp_cosine", 32'(rsp_cosine), 32'((j % 4) << 12));
      tick();
    end
    req_valid = 4'b0000;
    #1;
    chk("end_busy", 32'(busy), 32'h0);
    chk("end_cordic_angle_held", cordic_angle, 32'h0);

`ifdef CORDIC_ARB_STATS_EN
    chk("stat_done", 32'(stat_done), 32'd6);
`endif

    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
